// File: rtl/text_console_writer.sv
// Terminal-style writer for the text renderer's character RAM: printable bytes land at the cursor, CR/LF/BS/FF move it, clears fill with FILL.
// Writes issue one cycle after a byte is accepted; in_ready drops while a row or full-screen clear is running.
module text_console_writer #(
  parameter int         COLS     = 40,
  parameter int         ROWS     = 30,
  parameter int         COL_BITS = 6,
  parameter int         ROW_BITS = 6,
  parameter logic [7:0] FILL     = 8'h20
) (
  input  logic                         px_clk,
  input  logic                         rst,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         wr_en,
  output logic [ROW_BITS+COL_BITS-1:0] wr_addr,
  output logic [7:0]                   wr_data,
  output logic [COL_BITS-1:0]          cur_col,
  output logic [ROW_BITS-1:0]          cur_row
);

  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);

  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} state_t;

  state_t                       state_q, state_d;
  logic [COL_BITS-1:0]          col_q, col_d;
  logic [ROW_BITS-1:0]          row_q, row_d;
  logic [COL_BITS-1:0]          clr_col_q, clr_col_d;
  logic [ROW_BITS-1:0]          clr_row_q, clr_row_d;
  logic                         clr_done_q, clr_done_d;
  logic                         in_ready_q, in_ready_d;
  logic                         wr_en_q, wr_en_d;
  logic [ROW_BITS+COL_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]                   wr_data_q, wr_data_d;

  logic                         accept;
  logic                         is_print;
  logic [ROW_BITS-1:0]          row_inc;
  logic [ROW_BITS-1:0]          clr_row_sel;

  assign accept      = in_valid && in_ready_q;
  assign is_print    = (in_data >= 8'h20) && (in_data <= 8'h7E);
  assign row_inc     = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
  // A row clear targets the cursor row; a full clear walks its own row counter.
  assign clr_row_sel = (state_q == CLR_ALL) ? clr_row_q : row_q;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    clr_col_d  = clr_col_q;
    clr_row_d  = clr_row_q;
    clr_done_d = clr_done_q;
    in_ready_d = in_ready_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      CLR_ALL, CLR_ROW: begin
        in_ready_d = 1'b0;
        if (clr_done_q) begin
          // Extra cycle after the last write so in_ready rises once the clear is fully on the bus.
          state_d    = IDLE;
          in_ready_d = 1'b1;
          clr_done_d = 1'b0;
          clr_col_d  = '0;
          clr_row_d  = '0;
        end else begin
          wr_en_d   = 1'b1;
          wr_data_d = FILL;
          wr_addr_d = {clr_row_sel, clr_col_q};
          if (clr_col_q == LAST_COL) begin
            clr_col_d = '0;
            if ((state_q == CLR_ROW) || (clr_row_q == LAST_ROW)) begin
              clr_done_d = 1'b1;
            end else begin
              clr_row_d = clr_row_q + 1'b1;
            end
          end else begin
            clr_col_d = clr_col_q + 1'b1;
          end
        end
      end

      IDLE: begin
        in_ready_d = 1'b1;
        if (accept) begin
          if (is_print) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {row_q, col_q};
            wr_data_d = in_data;
            if (col_q == LAST_COL) begin
              col_d      = '0;
              row_d      = row_inc;
              state_d    = CLR_ROW;
              in_ready_d = 1'b0;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            case (in_data)
              8'h0A: begin
                col_d      = '0;
                row_d      = row_inc;
                state_d    = CLR_ROW;
                in_ready_d = 1'b0;
              end
              8'h0D: col_d = '0;
              8'h08: begin
                if (col_q != '0) begin
                  col_d     = col_q - 1'b1;
                  wr_en_d   = 1'b1;
                  wr_addr_d = {row_q, col_q - 1'b1};
                  wr_data_d = FILL;
                end
              end
              8'h0C: begin
                col_d      = '0;
                row_d      = '0;
                clr_col_d  = '0;
                clr_row_d  = '0;
                state_d    = CLR_ALL;
                in_ready_d = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end

      default: begin
        state_d    = CLR_ALL;
        in_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge px_clk) begin
    if (rst) begin
      state_q    <= CLR_ALL;
      col_q      <= '0;
      row_q      <= '0;
      clr_col_q  <= '0;
      clr_row_q  <= '0;
      clr_done_q <= 1'b0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= FILL;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      clr_col_q  <= clr_col_d;
      clr_row_q  <= clr_row_d;
      clr_done_q <= clr_done_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cur_col  = col_q;
  assign cur_row  = row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: a schedule-of-writes reference model checked every cycle,
// plus directed scenarios with literal expectations and a random byte stream.
module tb_text_console_writer;

  logic        px_clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [5:0]  cur_col;
  logic [5:0]  cur_row;

  text_console_writer dut (
    .px_clk   (px_clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cur_col  (cur_col),
    .cur_row  (cur_row)
  );

  always #5 px_clk = ~px_clk;

  int vec = 0;
  int miss = 0;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    vec++;
    if (got !== want) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endfunction

  // Reference model: expected bus contents for each upcoming cycle, plus the cursor.
  typedef struct packed {
    logic        en;
    logic        rdy;
    logic [11:0] addr;
    logic [7:0]  data;
    logic        chk_bus;
  } ent_t;

  ent_t sched[$];
  ent_t cur;
  int   mcol = 0;
  int   mrow = 0;
  bit   pend_clear = 1'b0;
  bit   started = 1'b0;

  function automatic void push_row(input int r);
    for (int c = 0; c < 40; c++)
      sched.push_back('{1'b1, 1'b0, {6'(r), 6'(c)}, 8'h20, 1'b0});
  endfunction

  function automatic void push_screen();
    for (int r = 0; r < 30; r++) push_row(r);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      sched.push_back('{1'b1, (mcol != 39), {6'(mrow), 6'(mcol)}, b, 1'b0});
      if (mcol == 39) begin
        mcol = 0;
        mrow = (mrow + 1) % 30;
        push_row(mrow);
      end else begin
        mcol++;
      end
    end else if (b == 8'h0A) begin
      sched.push_back('{1'b0, 1'b0, 12'd0, 8'h00, 1'b0});
      mcol = 0;
      mrow = (mrow + 1) % 30;
      push_row(mrow);
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        sched.push_back('{1'b1, 1'b1, {6'(mrow), 6'(mcol)}, 8'h20, 1'b0});
      end
    end else if (b == 8'h0C) begin
      sched.push_back('{1'b0, 1'b0, 12'd0, 8'h00, 1'b0});
      mcol = 0;
      mrow = 0;
      push_screen();
    end
  endfunction

  initial begin
    forever begin
      @(posedge px_clk);
      if (rst) begin
        sched.delete();
        mcol = 0;
        mrow = 0;
        pend_clear = 1'b1;
        cur = '{1'b0, 1'b0, 12'd0, 8'h20, 1'b1};
      end else begin
        if (pend_clear) begin
          push_screen();
          pend_clear = 1'b0;
        end
        if (cur.rdy && in_valid) model_byte(in_data);
        if (sched.size() > 0) cur = sched.pop_front();
        else cur = '{1'b0, 1'b1, 12'd0, 8'h00, 1'b0};
      end
      started = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge px_clk);
      if (started) begin
        chk("wr_en", wr_en, cur.en);
        chk("in_ready", in_ready, cur.rdy);
        chk("cur_col", cur_col, mcol);
        chk("cur_row", cur_row, mrow);
        if (cur.en || cur.chk_bus) begin
          chk("wr_addr", wr_addr, cur.addr);
          chk("wr_data", wr_data, cur.data);
        end
      end
    end
  end

  // Writes are counted at the edge that commits them into the RAM.
  int          wr_cnt = 0;
  logic [11:0] last_addr = 12'hFFF;
  logic [7:0]  last_data = 8'hFF;

  initial begin
    forever begin
      @(posedge px_clk);
      if (wr_en === 1'b1) begin
        wr_cnt++;
        last_addr = wr_addr;
        last_data = wr_data;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int g;
    in_valid = 1'b1;
    in_data  = b;
    g = 0;
    while (in_ready !== 1'b1 && g < 3000) begin
      @(negedge px_clk);
      g++;
    end
    if (g >= 3000) begin
      vec++;
      miss++;
      $display("FAIL send_timeout: in_ready still %b, required 1", in_ready);
    end
    @(negedge px_clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    while (in_ready !== 1'b1 && g < 3000) begin
      @(negedge px_clk);
      g++;
    end
    if (g >= 3000) begin
      vec++;
      miss++;
      $display("FAIL ready_timeout: in_ready still %b, required 1", in_ready);
    end
  endtask

  task automatic settle();
    repeat (2) @(negedge px_clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int g;
    int r;
    logic [7:0] b;

    // Reset held for two edges, then the power-on clear.
    @(negedge px_clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_data", wr_data, 8'h20);
    chk("rst_wr_addr", wr_addr, 0);
    @(negedge px_clk);
    rst = 1'b0;
    wait_ready();
    chk("init_clear_writes", wr_cnt, 1200);
    chk("init_col", cur_col, 0);
    chk("init_row", cur_row, 0);

    // Single printable.
    base = wr_cnt;
    send(8'h41);
    settle();
    chk("A_writes", wr_cnt - base, 1);
    chk("A_addr", last_addr, 12'h000);
    chk("A_data", last_data, 8'h41);
    chk("A_col", cur_col, 1);
    chk("A_ready", in_ready, 1);

    // Full row back-to-back, wrapping into a row clear.
    send(8'h0D);
    base = wr_cnt;
    for (int i = 0; i < 40; i++) send(8'(8'h41 + (i % 26)));
    chk("wrap_ready_low", in_ready, 0);
    chk("wrap_col", cur_col, 0);
    chk("wrap_row", cur_row, 1);
    wait_ready();
    chk("wrap_writes", wr_cnt - base, 80);
    chk("wrap_last_addr", last_addr, {6'd1, 6'd39});
    chk("wrap_last_data", last_data, 8'h20);

    // Backspace at (5,3) and at (5,0).
    repeat (4) send(8'h0A);
    wait_ready();
    repeat (3) send(8'h78);
    send(8'h08);
    settle();
    chk("bs_addr", last_addr, {6'd5, 6'd2});
    chk("bs_data", last_data, 8'h20);
    chk("bs_col", cur_col, 2);
    send(8'h0D);
    base = wr_cnt;
    send(8'h08);
    settle();
    chk("bs0_writes", wr_cnt - base, 0);
    chk("bs0_col", cur_col, 0);
    chk("bs0_row", cur_row, 5);

    // CR at (29,7), LF wraps to row 0, BEL is dropped.
    repeat (24) send(8'h0A);
    wait_ready();
    repeat (7) send(8'h2E);
    send(8'h0D);
    settle();
    chk("cr_col", cur_col, 0);
    chk("cr_row", cur_row, 29);
    base = wr_cnt;
    send(8'h0A);
    wait_ready();
    chk("lf_wrap_writes", wr_cnt - base, 40);
    chk("lf_wrap_row", cur_row, 0);
    chk("lf_wrap_last_addr", last_addr, {6'd0, 6'd39});
    base = wr_cnt;
    send(8'h07);
    settle();
    chk("bel_writes", wr_cnt - base, 0);
    chk("bel_ready", in_ready, 1);

    // Random byte stream with idle gaps; busy periods hold the byte.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      b = 8'($urandom_range(32, 126));
      else if (r < 78) b = 8'h0A;
      else if (r < 83) b = 8'h0D;
      else if (r < 90) b = 8'h08;
      else if (r < 92) b = 8'h0C;
      else             b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge px_clk);
      send(b);
    end
    wait_ready();

    // Form feed interrupted by reset on its 100th write.
    send(8'h0C);
    base = wr_cnt;
    g = 0;
    while (!((wr_cnt - base) == 99 && wr_en === 1'b1) && g < 3000) begin
      @(negedge px_clk);
      g++;
    end
    if (g >= 3000) begin
      vec++;
      miss++;
      $display("FAIL ff_100th_write: never observed, writes seen %0d", wr_cnt - base);
    end
    rst = 1'b1;
    @(negedge px_clk);
    rst = 1'b0;
    base = wr_cnt;
    wait_ready();
    chk("ff_rst_writes", wr_cnt - base, 1200);
    chk("ff_rst_last_addr", last_addr, {6'd29, 6'd39});
    chk("ff_rst_col", cur_col, 0);
    chk("ff_rst_row", cur_row, 0);
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
